// File: rtl/link_arbiter_pkg.sv
// Shared flit geometry, FSM encodings and index helper
// for the gp_fifo write-port link arbiter.
package link_arbiter_pkg;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;
    localparam int FLIT_W = ADDR_W + DATA_W;
    localparam int IDX_W  = 3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] n_addr;
        logic [DATA_W-1:0] data;
    } flit_t;

    // Next requester index after idx, wrapping at n.
    function automatic logic [IDX_W-1:0] wrap_inc(
        input logic [IDX_W-1:0] idx,
        input int               n
    );
        if (int'(idx) + 1 >= n) begin
            return '0;
        end
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/link_arbiter_rr_pick.sv
// Round-robin priority picker: first set request
// at or after the pointer, wrapping around.
module link_arbiter_rr_pick
    import link_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Scan offsets from the pointer; the first hit wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int c;
            c = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_any && i_req[c]) begin
                o_any    = 1'b1;
                o_gnt[c] = 1'b1;
                o_idx    = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/link_arbiter.sv
// Round-robin burst arbiter feeding one gp_fifo write port
// through a single output holding register.
module link_arbiter
    import link_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [ADDR_W*NUM_REQ-1:0]  req_n_addr,
    input  logic [DATA_W*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ack,
    output logic                       fifo_write_en,
    output logic [FLIT_W-1:0]          fifo_data_in,
    input  logic                       fifo_full,
    input  logic                       fifo_error,
    output logic [IDX_W-1:0]           grant_id,
    output logic                       busy,
    output logic                       burst_err,
    output logic                       link_err
);

    localparam int BC_W = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] BC_MAX = BC_W'(MAX_BURST);

    logic [0:0]         r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_grant;
    logic [BC_W-1:0]    r_beat;
    logic               r_hv;
    flit_t              r_hdata;
    logic               r_burst_err;
    logic               r_link_err;

    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic [NUM_REQ-1:0] w_owner_mask;
    logic [NUM_REQ-1:0] w_ack;
    logic               w_write;
    logic               w_can_load;
    logic               w_load;
    logic               w_idle;
    logic [IDX_W-1:0]   w_sel_idx;
    flit_t              w_sel_flit;
    logic               w_sel_last;
    logic [BC_W-1:0]    w_beat_next;
    logic               w_end;

    link_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Hold register drains when the FIFO has room; a
    // free or draining register can take a new flit.
    assign w_idle     = (r_state == ST_IDLE);
    assign w_write    = r_hv & ~fifo_full & ~reset;
    assign w_can_load = (~r_hv | ~fifo_full) & ~reset;

    // One-hot mask of the current burst owner.
    always_comb begin
        w_owner_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_owner_mask[i] = (r_grant == IDX_W'(i));
        end
    end

    // Ack: fresh pick when idle, owner only during a burst.
    always_comb begin
        w_ack = '0;
        if (w_can_load) begin
            if (w_idle) begin
                w_ack = w_pick_any ? w_pick_gnt : '0;
            end else begin
                w_ack = req_valid & w_owner_mask;
            end
        end
    end

    assign w_load    = |w_ack;
    assign w_sel_idx = w_idle ? w_pick_idx : r_grant;

    // Mux the selected requester's flit and last flag.
    always_comb begin
        w_sel_flit = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel_idx == IDX_W'(i)) begin
                w_sel_flit.n_addr = req_n_addr[ADDR_W*i +: ADDR_W];
                w_sel_flit.data   = req_data[DATA_W*i +: DATA_W];
                w_sel_last        = req_last[i];
            end
        end
    end

    assign w_beat_next = w_idle ? BC_W'(1) : r_beat + BC_W'(1);
    assign w_end       = w_sel_last | (w_beat_next == BC_MAX);

    // Grant FSM, round-robin pointer and beat counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_beat      <= '0;
            r_burst_err <= 1'b0;
        end else if (w_load) begin
            r_grant <= w_sel_idx;
            r_beat  <= w_beat_next;
            if (w_end) begin
                r_state  <= ST_IDLE;
                r_rr_ptr <= wrap_inc(w_sel_idx, NUM_REQ);
                if (!w_sel_last) begin
                    r_burst_err <= 1'b1;
                end
            end else begin
                r_state <= ST_BURST;
            end
        end
    end

    // Output holding register with pass-through refill.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hv    <= 1'b0;
            r_hdata <= '0;
        end else if (w_load) begin
            r_hv    <= 1'b1;
            r_hdata <= w_sel_flit;
        end else if (w_write) begin
            r_hv    <= 1'b0;
        end
    end

    // Sticky downstream FIFO error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_link_err <= 1'b0;
        end else if (fifo_error) begin
            r_link_err <= 1'b1;
        end
    end

    assign req_ack       = w_ack;
    assign fifo_write_en = w_write;
    assign fifo_data_in  = r_hdata;
    assign grant_id      = r_grant;
    assign busy          = (r_state == ST_BURST);
    assign burst_err     = r_burst_err;
    assign link_err      = r_link_err;

endmodule

// File: tb/tb_link_arbiter.sv
// Directed and randomized bench for link_arbiter,
// checked against a transaction-level model.
module tb_link_arbiter;

    localparam int N  = 4;
    localparam int MB = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [2*N-1:0]  req_n_addr;
    logic [32*N-1:0] req_data;
    logic [N-1:0]    req_ack;
    logic            fifo_write_en;
    logic [33:0]     fifo_data_in;
    logic            fifo_full;
    logic            fifo_error;
    logic [2:0]      grant_id;
    logic            busy;
    logic            burst_err;
    logic            link_err;

    always #5 clk = ~clk;

    link_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_n_addr    (req_n_addr),
        .req_data      (req_data),
        .req_ack       (req_ack),
        .fifo_write_en (fifo_write_en),
        .fifo_data_in  (fifo_data_in),
        .fifo_full     (fifo_full),
        .fifo_error    (fifo_error),
        .grant_id      (grant_id),
        .busy          (busy),
        .burst_err     (burst_err),
        .link_err      (link_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: packet-level view of the arbiter.
    bit          m_hv;
    logic [33:0] m_hdata;
    bit          m_busy;
    int          m_owner;
    int          m_beats;
    int          m_ptr;
    bit          m_berr;
    bit          m_lerr;

    logic [N-1:0] obs_ack;
    logic         obs_we;
    logic [33:0]  obs_data;
    logic         obs_busy;
    logic [2:0]   obs_grant;
    logic         obs_berr;
    logic         obs_lerr;

    task automatic chk(input string tag, input string what,
                       input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h",
                   tag, what, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hv = 0; m_hdata = '0; m_busy = 0; m_owner = 0;
        m_beats = 0; m_ptr = 0; m_berr = 0; m_lerr = 0;
    endtask

    function automatic logic [N-1:0] exp_ack();
        if (m_hv && fifo_full) return '0;
        if (m_busy) return req_valid[m_owner] ? N'(1) << m_owner : '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) return N'(1) << idx;
        end
        return '0;
    endfunction

    // One clock: check every output mid-cycle, then advance the model.
    task automatic step(input string tag);
        logic [N-1:0] ea;
        int w;
        @(negedge clk);
        obs_ack = req_ack; obs_we = fifo_write_en;
        obs_data = fifo_data_in; obs_busy = busy;
        obs_grant = grant_id; obs_berr = burst_err; obs_lerr = link_err;
        ea = exp_ack();
        chk(tag, "ack",   obs_ack,   ea);
        chk(tag, "we",    obs_we,    m_hv && !fifo_full);
        chk(tag, "data",  obs_data,  m_hdata);
        chk(tag, "busy",  obs_busy,  m_busy);
        chk(tag, "grant", obs_grant, m_owner[2:0]);
        chk(tag, "berr",  obs_berr,  m_berr);
        chk(tag, "lerr",  obs_lerr,  m_lerr);
        if (ea != 0) begin
            w = 0;
            for (int i = 0; i < N; i++) if (ea[i]) w = i;
            m_hv = 1;
            m_hdata = {req_n_addr[2*w +: 2], req_data[32*w +: 32]};
            if (!m_busy) begin
                m_owner = w;
                m_beats = 1;
            end else begin
                m_beats++;
            end
            if (req_last[w] || m_beats == MB) begin
                if (!req_last[w]) m_berr = 1;
                m_busy = 0;
                m_ptr = (w + 1) % N;
            end else begin
                m_busy = 1;
            end
        end else if (m_hv && !fifo_full) begin
            m_hv = 0;
        end
        if (fifo_error) m_lerr = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; req_valid = '0; req_last = '0;
        fifo_full = 0; fifo_error = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
    endtask

    int acks;
    int lp;

    initial begin
        reset = 1; req_valid = '0; req_last = '0;
        req_n_addr = '0; req_data = '0;
        fifo_full = 0; fifo_error = 0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset state and single flit.
        do_reset();
        step("reset");
        chk("reset", "we0", obs_we, 0);
        chk("reset", "data0", obs_data, 0);
        req_valid = 4'b0001; req_last = 4'b1111;
        req_n_addr = 8'h02; req_data[31:0] = 32'hDEAD_BEEF;
        step("t1a");
        chk("t1", "ack0", obs_ack, 4'b0001);
        req_valid = '0;
        step("t1b");
        chk("t1", "we", obs_we, 1);
        chk("t1", "flit", obs_data, 34'h2_DEAD_BEEF);

        // Round-robin among four single-flit packets.
        do_reset();
        req_valid = 4'b1111; req_last = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            req_data = {4{32'(k)}};
            step("t2");
            chk("t2", "order", obs_ack, 4'b0001 << (k % 4));
        end

        // Three-flit burst from req1 holds the grant.
        do_reset();
        req_valid = 4'b0001; req_last = 4'b1111;
        step("t3pre");
        req_valid = 4'b0111;
        for (int k = 0; k < 4; k++) begin
            req_last = (k >= 2) ? 4'b1111 : 4'b1101;
            req_data = {4{32'(100 + k)}};
            step("t3");
            chk("t3", "order", obs_ack, (k < 3) ? 4'b0010 : 4'b0100);
        end

        // Backpressure keeps the held flit stable.
        do_reset();
        req_valid = 4'b0001; req_last = 4'b1111;
        req_n_addr = 8'h01; req_data = {4{32'hAAAA_0001}};
        step("t4load");
        req_valid = 4'b0010; fifo_full = 1;
        req_n_addr = 8'h0C; req_data = {4{32'hBBBB_0002}};
        for (int k = 0; k < 5; k++) begin
            step("t4full");
            chk("t4", "noack", obs_ack, 0);
            chk("t4", "nowe", obs_we, 0);
            chk("t4", "hold", obs_data, 34'h1_AAAA_0001);
        end
        fifo_full = 0;
        step("t4drop");
        chk("t4", "we", obs_we, 1);
        chk("t4", "refill", obs_ack, 4'b0010);
        req_valid = '0;
        step("t4next");
        chk("t4", "flitB", obs_data, 34'h3_BBBB_0002);

        // Burst forced off at MAX_BURST, then re-arbitrated.
        do_reset();
        req_last = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            req_valid = (k >= 7) ? 4'b1001 : 4'b1000;
            req_data = {4{32'(200 + k)}};
            step("t5");
            if (k < 8) chk("t5", "owner", obs_ack, 4'b1000);
            if (k == 8) begin
                chk("t5", "moved", obs_ack, 4'b0001);
                chk("t5", "berr", obs_berr, 1);
                chk("t5", "idle", obs_busy, 0);
            end
            if (k == 9) chk("t5", "rearb", obs_ack, 4'b1000);
        end

        // fifo_error mid-burst, then reset.
        do_reset();
        req_valid = 4'b0100; req_last = 4'b0000;
        step("t6a");
        step("t6b");
        req_valid = '0; fifo_error = 1;
        step("t6err");
        fifo_error = 0;
        step("t6c");
        chk("t6", "lerr", obs_lerr, 1);
        chk("t6", "busy", obs_busy, 1);
        do_reset();
        step("t6rst");
        chk("t6", "lerr0", obs_lerr, 0);
        chk("t6", "busy0", obs_busy, 0);
        req_valid = 4'b1111; req_last = 4'b1111;
        step("t6re");
        chk("t6", "restart", obs_ack, 4'b0001);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            lp = (k / 150) % 2 == 0 ? 2 : 15;
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_last[i] = ($urandom_range(0, lp) == 0);
            end
            req_n_addr = 8'($urandom);
            for (int i = 0; i < N; i++) req_data[32*i +: 32] = $urandom;
            fifo_full  = ($urandom_range(0, 3) == 0);
            fifo_error = ($urandom_range(0, 60) == 0);
            if (k % 200 == 199) do_reset();
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
